controlador_es: RTL and testbench

- Controller for the memory-mapped I/O region of the single-cycle datapath. That region is any data-memory access whose 8-bit effective address has bit 7 set.
- Takes the datapath's I/O access request and arbitrates it onto one of NPUERTOS peripheral ports using a req/ack handshake.
- Stalls the CPU (freezes PC, register and stack writes) until the peripheral acks or a timeout expires.
- Returns read data to the datapath's memory/I/O result mux.

---
 rtl/controlador_es_if.sv | 35 +++
 rtl/controlador_es.sv | 133 +++++++++++++
 tb/tb_controlador_es.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_es_if.sv
`default_nettype none
// ============================================================================
// Module   : controlador_es_if
// Brief    : Peripheral req/ack bus between the I/O controller and its ports.
// Revision : 1.0 - initial release
// ============================================================================
interface controlador_es_if #(
    parameter int NPUERTOS = 4
);
    logic [NPUERTOS-1:0]   per_req;
    logic                  per_we;
    logic [4:0]            per_dir;
    logic [7:0]            per_dato_sal;
    logic [8*NPUERTOS-1:0] per_dato_ent;
    logic [NPUERTOS-1:0]   per_ack;

    modport master (
        output per_req,
        output per_we,
        output per_dir,
        output per_dato_sal,
        input  per_dato_ent,
        input  per_ack
    );

    modport slave (
        input  per_req,
        input  per_we,
        input  per_dir,
        input  per_dato_sal,
        output per_dato_ent,
        output per_ack
    );
endinterface
`default_nettype wire

// File: rtl/controlador_es.sv
`default_nettype none
// ============================================================================
// Module   : controlador_es
// Brief    : Memory-mapped I/O controller: stalls the CPU while one peripheral
//            port completes a req/ack access, with timeout and error flag.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_es #(
    parameter int NPUERTOS  = 4,
    parameter int TIMEOUT   = 15,
    parameter int ANCHO_CNT = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       activar_es,
    input  wire logic       escribir_es,
    input  wire logic [6:0] direccion_es,
    input  wire logic [7:0] dato_entrada_es,
    output logic      [7:0] dato_salida_es,
    output logic            parar,
    output logic            error_es,
    controlador_es_if.master bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ESPERA = 2'd1;
    localparam logic [1:0] c_FIN    = 2'd2;

    localparam logic [ANCHO_CNT-1:0] c_CNT_MAX = ANCHO_CNT'(TIMEOUT - 1);

    logic [1:0]           r_estado;
    logic [ANCHO_CNT-1:0] r_cnt;
    logic [NPUERTOS-1:0]  r_perReq;
    logic                 r_perWe;
    logic [4:0]           r_perDir;
    logic [7:0]           r_perDatoSal;
    logic [7:0]           r_datoSalida;
    logic                 r_error;

    logic [1:0]           w_puerto;
    logic                 w_mapeado;
    logic [NPUERTOS-1:0]  w_selOneHot;
    logic                 w_ack;
    logic [7:0]           w_datoLeido;

    assign w_puerto  = direccion_es[6:5];
    assign w_mapeado = ({1'b0, w_puerto} < 3'(NPUERTOS));

    generate
        for (genvar k = 0; k < NPUERTOS; k++) begin : g_sel
            assign w_selOneHot[k] = (w_puerto == 2'(k));
        end
    endgenerate

    // r_perReq is one-hot, so masking the acks ignores strays on other ports.
    assign w_ack = |(bus.per_ack & r_perReq);

    always_comb begin
        w_datoLeido = '0;
        for (int k = 0; k < NPUERTOS; k++) begin
            if (r_perReq[k]) begin
                w_datoLeido = w_datoLeido | bus.per_dato_ent[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado     <= c_IDLE;
            r_cnt        <= '0;
            r_perReq     <= '0;
            r_perWe      <= 1'b0;
            r_perDir     <= '0;
            r_perDatoSal <= '0;
            r_datoSalida <= '0;
            r_error      <= 1'b0;
        end else begin
            case (r_estado)
                c_IDLE: begin
                    if (activar_es) begin
                        r_perDir     <= direccion_es[4:0];
                        r_perWe      <= escribir_es;
                        r_perDatoSal <= dato_entrada_es;
                        r_cnt        <= '0;
                        if (w_mapeado) begin
                            r_perReq <= w_selOneHot;
                            r_estado <= c_ESPERA;
                        end else begin
                            r_datoSalida <= 8'hFF;
                            r_error      <= 1'b1;
                            r_estado     <= c_FIN;
                        end
                    end
                end
                c_ESPERA: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Ack is tested first so an ack on the last cycle beats the timeout.
                    if (w_ack) begin
                        r_perReq <= '0;
                        r_estado <= c_FIN;
                        if (!r_perWe) begin
                            r_datoSalida <= w_datoLeido;
                        end
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_perReq     <= '0;
                        r_datoSalida <= 8'hFF;
                        r_error      <= 1'b1;
                        r_estado     <= c_FIN;
                    end
                end
                c_FIN: begin
                    r_estado <= c_IDLE;
                end
                default: begin
                    r_perReq <= '0;
                    r_estado <= c_IDLE;
                end
            endcase
        end
    end

    // Request cycle stalls combinationally so the PC never advances past an I/O access.
    assign parar = ((r_estado == c_IDLE) && activar_es) || (r_estado == c_ESPERA);

    assign dato_salida_es   = r_datoSalida;
    assign error_es         = r_error;
    assign bus.per_req      = r_perReq;
    assign bus.per_we       = r_perWe;
    assign bus.per_dir      = r_perDir;
    assign bus.per_dato_sal = r_perDatoSal;

endmodule
`default_nettype wire

// File: tb/tb_controlador_es.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_es
// Brief    : Self-checking bench: vector table, random accesses against a
//            transaction-level model, reset and unmapped-port sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_es;

    localparam int c_TO4 = 15;
    localparam int c_NEVER = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-port instance
    logic       activar, escribir;
    logic [6:0] direccion;
    logic [7:0] datoEnt, datoSal;
    logic       parar, errorEs;
    controlador_es_if #(.NPUERTOS(4)) bus4 ();

    controlador_es #(.NPUERTOS(4), .TIMEOUT(c_TO4), .ANCHO_CNT(8)) dut4 (
        .clk(clk), .reset(reset), .activar_es(activar), .escribir_es(escribir),
        .direccion_es(direccion), .dato_entrada_es(datoEnt), .dato_salida_es(datoSal),
        .parar(parar), .error_es(errorEs), .bus(bus4.master)
    );

    // 2-port instance for the unmapped-port case
    logic       activar2, escribir2;
    logic [6:0] direccion2;
    logic [7:0] datoEnt2, datoSal2;
    logic       parar2, errorEs2;
    controlador_es_if #(.NPUERTOS(2)) bus2 ();

    controlador_es #(.NPUERTOS(2), .TIMEOUT(3), .ANCHO_CNT(2)) dut2 (
        .clk(clk), .reset(reset), .activar_es(activar2), .escribir_es(escribir2),
        .direccion_es(direccion2), .dato_entrada_es(datoEnt2), .dato_salida_es(datoSal2),
        .parar(parar2), .error_es(errorEs2), .bus(bus2.master)
    );

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: result of one access from the access rules.
    logic [7:0] mDato;
    logic       mErr;

    task automatic model(input logic [6:0] addr, input logic we, input logic [7:0] rdata,
                         input int d, output int stall, output logic [7:0] dato,
                         output logic err);
        if (d <= c_TO4 - 1) begin
            stall = d + 2;
            if (!we) mDato = rdata;
        end else begin
            stall = c_TO4 + 1;
            mDato = 8'hFF;
            mErr  = 1'b1;
        end
        dato = mDato;
        err  = mErr;
    endtask

    // One full access on dut4; d = ESPERA cycle index (0-based) of the ack.
    task automatic run_access(input string name, input logic [6:0] addr, input logic we,
                              input logic [7:0] wdata, input logic [7:0] rdata, input int d,
                              input bit stray, input int expStall, input logic [7:0] expDato,
                              input logic expErr);
        int port;
        int stall;
        bit done;
        logic [3:0] oneHot;
        port   = int'(addr[6:5]);
        oneHot = 4'b0001 << port;
        stall  = 0;
        done   = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            activar   = 1'b1;
            escribir  = we;
            direccion = addr;
            datoEnt   = wdata;
            bus4.per_dato_ent = {$urandom};
            bus4.per_dato_ent[port*8 +: 8] = rdata;
            bus4.per_ack = (c == d + 1) ? oneHot : 4'b0000;
            if (stray) bus4.per_ack = bus4.per_ack | ~oneHot;
            #1;
            if (parar) begin
                stall++;
                if (c >= 1) begin
                    check({name, " bus"},
                          {bus4.per_req, bus4.per_dir, bus4.per_we, bus4.per_dato_sal},
                          {oneHot, addr[4:0], we, wdata});
                end
            end else begin
                done = 1'b1;
                check({name, " stall"}, stall, expStall);
                check({name, " dato"}, datoSal, expDato);
                check({name, " error"}, errorEs, expErr);
                check({name, " req_fin"}, bus4.per_req, 4'b0000);
            end
        end
        if (!done) check({name, " completion"}, 0, 1);
        bus4.per_ack = 4'b0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            activar      = 1'b0;
            bus4.per_ack = 4'b0000;
        end
    endtask

    typedef struct {
        string      name;
        logic [6:0] addr;
        logic       we;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         d;
        bit         stray;
        int         expStall;
        logic [7:0] expDato;
        logic       expErr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"rd_p1",   7'h25, 1'b0, 8'h00, 8'hA5, 0,       1'b0, 2,  8'hA5, 1'b0};
        vecs[1] = '{"wr_p3",   7'h7F, 1'b1, 8'h3C, 8'h00, 3,       1'b0, 5,  8'hA5, 1'b0};
        vecs[2] = '{"stray_p2",7'h43, 1'b0, 8'h00, 8'h5A, 2,       1'b1, 4,  8'h5A, 1'b0};
        vecs[3] = '{"ack_edge",7'h21, 1'b0, 8'h00, 8'h77, 14,      1'b0, 16, 8'h77, 1'b0};
        vecs[4] = '{"tmo_p0",  7'h00, 1'b0, 8'h00, 8'h33, c_NEVER, 1'b0, 16, 8'hFF, 1'b1};
        vecs[5] = '{"sticky",  7'h6A, 1'b0, 8'h00, 8'h12, 1,       1'b0, 3,  8'h12, 1'b1};

        reset = 1'b1;
        activar = 1'b0; escribir = 1'b0; direccion = '0; datoEnt = '0;
        activar2 = 1'b0; escribir2 = 1'b0; direccion2 = '0; datoEnt2 = '0;
        bus4.per_ack = '0; bus4.per_dato_ent = '0;
        bus2.per_ack = '0; bus2.per_dato_ent = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        check("rst_outs", {parar, errorEs, datoSal}, {1'b0, 1'b0, 8'h00});
        check("rst_bus", {bus4.per_req, bus4.per_we, bus4.per_dir, bus4.per_dato_sal}, '0);

        for (int i = 0; i < 6; i++) begin
            run_access(vecs[i].name, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].rdata,
                       vecs[i].d, vecs[i].stray, vecs[i].expStall, vecs[i].expDato,
                       vecs[i].expErr);
        end

        // Random accesses, some back-to-back, against the model.
        mDato = 8'h12;
        mErr  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [6:0] a;
            logic       w;
            logic [7:0] wd, rd, eDato;
            logic       eErr;
            int         d, eStall;
            a  = 7'($urandom);
            w  = 1'($urandom);
            wd = 8'($urandom);
            rd = 8'($urandom);
            d  = $urandom_range(0, 19);
            if (d >= 17) d = c_NEVER;
            model(a, w, rd, d, eStall, eDato, eErr);
            run_access("rand", a, w, wd, rd, d, 1'($urandom), eStall, eDato, eErr);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);

        // Reset during the second ESPERA cycle of a port-1 access.
        @(negedge clk);
        activar = 1'b1; escribir = 1'b0; direccion = 7'h25; bus4.per_ack = '0;
        @(negedge clk); #1;
        check("mid_esp1_req", bus4.per_req, 4'b0010);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; activar = 1'b0;
        #1;
        check("mid_rst_outs", {parar, errorEs, datoSal}, {1'b0, 1'b0, 8'h00});
        check("mid_rst_bus", {bus4.per_req, bus4.per_we, bus4.per_dir}, '0);
        mDato = 8'h00;
        mErr  = 1'b0;
        run_access("post_rst", 7'h25, 1'b0, 8'h00, 8'hC3, 1, 1'b0, 3, 8'hC3, 1'b0);
        idle(1);

        // Unmapped port on the 2-port instance, then a good access.
        @(negedge clk);
        activar2 = 1'b1; direccion2 = 7'h60; escribir2 = 1'b0;
        #1;
        check("unm_req_cycle", {parar2, bus2.per_req}, {1'b1, 2'b00});
        @(negedge clk); #1;
        check("unm_fin", {parar2, errorEs2, datoSal2, bus2.per_req}, {1'b0, 1'b1, 8'hFF, 2'b00});
        @(negedge clk);
        activar2 = 1'b0;
        #1;
        check("unm_idle", {parar2, bus2.per_req}, {1'b0, 2'b00});
        @(negedge clk);
        activar2 = 1'b1; direccion2 = 7'h22; bus2.per_dato_ent = {8'h99, 8'h11};
        #1;
        check("p2_req_cycle", parar2, 1'b1);
        @(negedge clk);
        bus2.per_ack = 2'b10;
        #1;
        check("p2_espera", {parar2, bus2.per_req, bus2.per_dir}, {1'b1, 2'b10, 5'h02});
        @(negedge clk);
        bus2.per_ack = 2'b00;
        #1;
        check("p2_fin", {parar2, errorEs2, datoSal2}, {1'b0, 1'b1, 8'h99});
        @(negedge clk);
        activar2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
